// File: rtl/arcade_input.sv
// Player input and configuration front end: keyboard/joystick merge with SOCD
// cleaning, coin pulse stretching with lockout, and DIP/game capture from ioctl.
module arcade_input #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_DIPS = 8,
    parameter int COIN_CYCLES = 1600000,
    parameter logic [7:0] DIP_DEFAULT = 8'h00
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [10:0]                ps2_key,
    input  logic [16*NUM_PLAYERS-1:0]  joystick,
    input  logic [1:0]                 socd_mode,
    input  logic [24:0]                ioctl_addr,
    input  logic [7:0]                 ioctl_data,
    input  logic                       ioctl_wr,
    input  logic [7:0]                 ioctl_index,
    output logic [4*NUM_PLAYERS-1:0]   joy,
    output logic [4*NUM_PLAYERS-1:0]   buttons,
    output logic [NUM_PLAYERS-1:0]     start,
    output logic [NUM_PLAYERS-1:0]     coin,
    output logic [8*NUM_DIPS-1:0]      dip,
    output logic [3:0]                 game_index
);
    localparam int CW = $clog2(2 * COIN_CYCLES + 1);
    localparam logic [CW-1:0] COIN_LOAD = CW'(2 * COIN_CYCLES);
    localparam logic [CW-1:0] COIN_HI1 = CW'(COIN_CYCLES + 1);

    typedef enum logic [1:0] {S_NONE, S_A, S_B, S_NEUT} socd_t;

    logic            toggle_reg;
    logic [1:0][9:0] key_reg;
    logic [5:0]      key_sel;
    logic [3:0]      game_index_reg;

    // key_sel = {hit, player, bit} where bit follows the joystick bit layout
    always_comb begin
        key_sel = '0;
        case ({ps2_key[8], ps2_key[7:0]})
            9'h175: key_sel = {2'b10, 4'd3};
            9'h172: key_sel = {2'b10, 4'd2};
            9'h16B: key_sel = {2'b10, 4'd1};
            9'h174: key_sel = {2'b10, 4'd0};
            9'h014: key_sel = {2'b10, 4'd4};
            9'h011: key_sel = {2'b10, 4'd5};
            9'h029: key_sel = {2'b10, 4'd6};
            9'h012: key_sel = {2'b10, 4'd7};
            9'h016: key_sel = {2'b10, 4'd8};
            9'h02E: key_sel = {2'b10, 4'd9};
            9'h02D: key_sel = {2'b11, 4'd3};
            9'h02B: key_sel = {2'b11, 4'd2};
            9'h023: key_sel = {2'b11, 4'd1};
            9'h034: key_sel = {2'b11, 4'd0};
            9'h01C: key_sel = {2'b11, 4'd4};
            9'h01B: key_sel = {2'b11, 4'd5};
            9'h015: key_sel = {2'b11, 4'd6};
            9'h01D: key_sel = {2'b11, 4'd7};
            9'h01E: key_sel = {2'b11, 4'd8};
            9'h036: key_sel = {2'b11, 4'd9};
            default: key_sel = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            toggle_reg <= 1'b0;
            key_reg    <= '0;
        end else begin
            toggle_reg <= ps2_key[10];
            if ((ps2_key[10] != toggle_reg) && key_sel[5])
                key_reg[key_sel[4]][key_sel[3:0]] <= ps2_key[9];
        end
    end

    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
        logic [9:0]    kb_state;
        logic [9:0]    raw;
        logic [1:0]    out_a;
        logic [1:0]    out_b;
        logic [3:0]    joy_reg;
        logic [3:0]    btn_reg;
        logic          start_reg;
        logic          coin_reg;
        logic          coin_prev_reg;
        logic [CW-1:0] coin_cnt_reg;
        logic          unused_joy;

        if (gi < 2) begin : g_kb
            assign kb_state = key_reg[gi];
        end else begin : g_nokb
            assign kb_state = '0;
        end

        assign raw = joystick[16*gi +: 10] | kb_state;
        assign unused_joy = ^joystick[16*gi+10 +: 6];

        // axis 0: a=left, b=right; axis 1: a=up, b=down
        for (genvar gj = 0; gj < 2; gj++) begin : g_axis
            logic  a, b, oa, ob;
            logic  pa_reg, pb_reg;
            socd_t st_reg, st_next;

            assign a = (gj == 1) ? raw[3] : raw[1];
            assign b = (gj == 1) ? raw[2] : raw[0];

            always_comb begin
                st_next = st_reg;
                case ({a, b})
                    2'b00: st_next = S_NONE;
                    2'b10: st_next = S_A;
                    2'b01: st_next = S_B;
                    default: begin
                        // both held: whichever rose most recently wins
                        if (!pa_reg && !pb_reg)
                            st_next = S_NEUT;
                        else if (pa_reg && !pb_reg)
                            st_next = S_B;
                        else if (!pa_reg && pb_reg)
                            st_next = S_A;
                    end
                endcase
            end

            always_comb begin
                if (socd_mode == 2'd2) begin
                    oa = (st_next == S_A);
                    ob = (st_next == S_B);
                end else if (socd_mode[0]) begin
                    oa = a & ~b;
                    ob = b & ~a;
                end else begin
                    oa = a;
                    ob = b;
                end
            end

            assign out_a[gj] = oa;
            assign out_b[gj] = ob;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    st_reg <= S_NONE;
                    pa_reg <= 1'b0;
                    pb_reg <= 1'b0;
                end else begin
                    st_reg <= st_next;
                    pa_reg <= a;
                    pb_reg <= b;
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                joy_reg       <= '0;
                btn_reg       <= '0;
                start_reg     <= 1'b0;
                coin_reg      <= 1'b0;
                coin_prev_reg <= 1'b0;
                coin_cnt_reg  <= '0;
            end else begin
                joy_reg       <= {out_a[1], out_b[1], out_b[0], out_a[0]};
                btn_reg       <= raw[7:4];
                start_reg     <= raw[8];
                coin_prev_reg <= raw[9];
                // counter runs 2C..1: pulse for the top C values, lockout below
                if (coin_cnt_reg == '0) begin
                    if (raw[9] && !coin_prev_reg) begin
                        coin_cnt_reg <= COIN_LOAD;
                        coin_reg     <= 1'b1;
                    end else begin
                        coin_reg <= 1'b0;
                    end
                end else begin
                    coin_cnt_reg <= coin_cnt_reg - CW'(1);
                    coin_reg     <= (coin_cnt_reg > COIN_HI1);
                end
            end
        end

        assign joy[4*gi +: 4]     = joy_reg;
        assign buttons[4*gi +: 4] = btn_reg;
        assign start[gi]          = start_reg;
        assign coin[gi]           = coin_reg;
    end

    for (genvar gi = 0; gi < NUM_DIPS; gi++) begin : g_dip
        logic [7:0] dip_reg;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                dip_reg <= DIP_DEFAULT;
            else if (ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr == 25'(gi)))
                dip_reg <= ioctl_data;
        end

        assign dip[8*gi +: 8] = dip_reg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            game_index_reg <= 4'd0;
        else if (ioctl_wr && (ioctl_index == 8'd1))
            game_index_reg <= ioctl_data[3:0];
    end

    assign game_index = game_index_reg;

endmodule

// File: tb/tb_arcade_input.sv
// Scoreboard bench for arcade_input: expectations are queued as stimulus is
// driven and popped once the DUT output is due.
module tb_arcade_input;
    localparam int NP = 2;
    localparam int ND = 8;
    localparam int CC = 4;
    localparam logic [7:0] DD = 8'hA5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] ps2_key = '0;
    logic [31:0] joystick = '0;
    logic [1:0]  socd_mode = '0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_index = '0;
    logic [7:0]  joy;
    logic [7:0]  buttons;
    logic [1:0]  start;
    logic [1:0]  coin;
    logic [63:0] dip;
    logic [3:0]  game_index;

    arcade_input #(
        .NUM_PLAYERS(NP), .NUM_DIPS(ND), .COIN_CYCLES(CC), .DIP_DEFAULT(DD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key), .joystick(joystick),
        .socd_mode(socd_mode), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
        .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .joy(joy), .buttons(buttons),
        .start(start), .coin(coin), .dip(dip), .game_index(game_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic        tog = 1'b0;
    logic [63:0] dip_model = {8{DD}};

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input int sel, input logic [63:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            0: return {56'd0, joy};
            1: return {56'd0, buttons};
            2: return {62'd0, start};
            3: return {62'd0, coin};
            4: return dip;
            default: return {60'd0, game_index};
        endcase
    endfunction

    task automatic test_reset;
        typedef struct packed { logic [7:0] idx; logic [24:0] addr; logic [7:0] data; } wr_t;
        wr_t         tab[4];
        exp_t        e;
        logic [63:0] got;
        step(2);
        push("reset_joy", 0, 64'd0);
        push("reset_buttons", 1, 64'd0);
        push("reset_start", 2, 64'd0);
        push("reset_coin", 3, 64'd0);
        push("reset_dip", 4, {8{DD}});
        push("reset_game", 5, 64'd0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            got = observe(e.sel);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", e.name, got, e.val);
            end
        end
        reset_n = 1'b1;
        step(1);
        tab = '{'{8'd254, 25'd3, 8'h5C}, '{8'd254, 25'd9, 8'hFF},
                '{8'd7, 25'd0, 8'h00}, '{8'd254, 25'd8, 8'h11}};
        for (int i = 0; i < 4; i++) begin
            ioctl_index = tab[i].idx;
            ioctl_addr  = tab[i].addr;
            ioctl_data  = tab[i].data;
            ioctl_wr    = 1'b1;
            if (tab[i].idx == 8'd254 && tab[i].addr < 25'(ND))
                dip_model[8*tab[i].addr[2:0] +: 8] = tab[i].data;
            push("dip_write", 4, dip_model);
            step(1);
            ioctl_wr = 1'b0;
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                got = observe(e.sel);
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL %s[%0d]: got %0h expected %0h", e.name, i, got, e.val);
                end
            end
        end
    endtask

    task automatic test_keyboard;
        typedef struct packed { logic pressed; logic ext; logic [7:0] code; logic [7:0] j; logic [7:0] b; } kb_t;
        kb_t         tab[7];
        exp_t        e;
        logic [63:0] got;
        logic [7:0]  pj = 8'h00;
        logic [7:0]  pb = 8'h00;
        tab = '{'{1'b1, 1'b1, 8'h6B, 8'h01, 8'h00},
                '{1'b1, 1'b0, 8'h6B, 8'h01, 8'h00},
                '{1'b1, 1'b0, 8'h2D, 8'h81, 8'h00},
                '{1'b1, 1'b0, 8'h14, 8'h81, 8'h01},
                '{1'b0, 1'b1, 8'h6B, 8'h80, 8'h01},
                '{1'b0, 1'b0, 8'h2D, 8'h00, 8'h01},
                '{1'b0, 1'b0, 8'h14, 8'h00, 8'h00}};
        for (int i = 0; i < 7; i++) begin
            tog = ~tog;
            ps2_key = {tog, tab[i].pressed, tab[i].ext, tab[i].code};
            // one cycle after the toggle nothing has reached the outputs yet
            for (int ph = 0; ph < 2; ph++) begin
                push(ph == 0 ? "kb_joy_early" : "kb_joy", 0, {56'd0, ph == 0 ? pj : tab[i].j});
                push(ph == 0 ? "kb_btn_early" : "kb_btn", 1, {56'd0, ph == 0 ? pb : tab[i].b});
                step(1);
                while (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    got = observe(e.sel);
                    checks++;
                    if (got !== e.val) begin
                        errors++;
                        $display("FAIL %s[%0d]: got %0h expected %0h", e.name, i, got, e.val);
                    end
                end
            end
            pj = tab[i].j;
            pb = tab[i].b;
        end
    endtask

    task automatic test_joystick;
        typedef struct packed { logic [31:0] js; logic [7:0] j; logic [7:0] b; logic [1:0] s; } js_t;
        js_t         tab[4];
        exp_t        e;
        logic [63:0] got;
        tab = '{'{32'h0000_0108, 8'h08, 8'h00, 2'b01},
                '{32'h00A4_0050, 8'h40, 8'hA5, 2'b00},
                '{32'h0100_F000, 8'h00, 8'h00, 2'b10},
                '{32'h0000_0000, 8'h00, 8'h00, 2'b00}};
        for (int i = 0; i < 4; i++) begin
            joystick = tab[i].js;
            push("js_joy", 0, {56'd0, tab[i].j});
            push("js_buttons", 1, {56'd0, tab[i].b});
            push("js_start", 2, {62'd0, tab[i].s});
            step(1);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                got = observe(e.sel);
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL %s[%0d]: got %0h expected %0h", e.name, i, got, e.val);
                end
            end
        end
    endtask

    task automatic test_socd;
        typedef struct packed { logic [1:0] mode; logic [31:0] js; logic [7:0] j; } sc_t;
        sc_t         tab[19];
        exp_t        e;
        logic [63:0] got;
        tab = '{'{2'd0, 32'h0, 8'h00},
                '{2'd1, 32'h3, 8'h00},
                '{2'd0, 32'h3, 8'h03},
                '{2'd3, 32'h000C_0000, 8'h00},
                '{2'd1, 32'h0008_0000, 8'h80},
                '{2'd0, 32'h0, 8'h00},
                '{2'd2, 32'h2, 8'h01},
                '{2'd2, 32'h3, 8'h02},
                '{2'd2, 32'h2, 8'h01},
                '{2'd2, 32'h0, 8'h00},
                '{2'd2, 32'h3, 8'h00},
                '{2'd2, 32'h3, 8'h00},
                '{2'd2, 32'h1, 8'h02},
                '{2'd2, 32'h0, 8'h00},
                '{2'd2, 32'h2, 8'h01},
                '{2'd2, 32'h3, 8'h02},
                '{2'd0, 32'h3, 8'h03},
                '{2'd2, 32'h3, 8'h02},
                '{2'd2, 32'h0, 8'h00}};
        for (int i = 0; i < 19; i++) begin
            socd_mode = tab[i].mode;
            joystick  = tab[i].js;
            push("socd_joy", 0, {56'd0, tab[i].j});
            step(1);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                got = observe(e.sel);
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL %s[%0d] mode=%0d: got %0h expected %0h", e.name, i, tab[i].mode, got, e.val);
                end
            end
        end
        socd_mode = 2'd0;
    endtask

    task automatic test_coin;
        exp_t        e;
        logic [63:0] got;
        logic        hi;
        joystick = '0;
        step(1);
        // held: one pulse of CC cycles starting one cycle after the edge, no retrigger
        joystick[25] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            hi = (c >= 1 && c <= CC);
            push("coin_held", 3, {62'd0, hi, 1'b0});
            step(1);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                got = observe(e.sel);
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL %s cycle %0d: got %0h expected %0h", e.name, c, got, e.val);
                end
            end
        end
        joystick[25] = 1'b0;
        step(1);
        // taps at cycle 0, 6 (lockout, ignored) and 9 (first accepted)
        for (int c = 0; c < 16; c++) begin
            joystick[25] = (c == 0 || c == 6 || c == 9);
            hi = ((c + 1) >= 1 && (c + 1) <= CC) || ((c + 1) >= 10 && (c + 1) <= 9 + CC);
            push("coin_retrig", 3, {62'd0, hi, 1'b0});
            step(1);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                got = observe(e.sel);
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL %s cycle %0d: got %0h expected %0h", e.name, c + 1, got, e.val);
                end
            end
        end
        joystick = '0;
        step(1);
    endtask

    task automatic test_game_reset;
        exp_t        e;
        logic [63:0] got;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin ioctl_index = 8'd1;   ioctl_addr = 25'd0; ioctl_data = 8'h37; ioctl_wr = 1'b1;
                         push("game_write", 5, 64'd7); push("dip_kept", 4, dip_model); end
                1: begin ioctl_index = 8'd2;   ioctl_addr = 25'd0; ioctl_data = 8'h0C; ioctl_wr = 1'b1;
                         push("game_other_index", 5, 64'd7); end
                2: begin ioctl_wr = 1'b0; joystick = 32'h0000_0200;
                         push("coin_p1_pulse", 3, 64'd1); end
                default: begin
                    push("reset_coin_async", 3, 64'd0);
                    push("reset_game_async", 5, 64'd0);
                    push("reset_dip_async", 4, {8{DD}});
                    push("reset_joy_async", 0, 64'd0);
                end
            endcase
            if (i < 3) begin
                step(1);
            end else begin
                // reset asserted between edges: outputs must clear before the next edge
                reset_n = 1'b0;
                #1;
            end
            ioctl_wr = 1'b0;
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                got = observe(e.sel);
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %0h expected %0h", e.name, got, e.val);
                end
            end
        end
        joystick = '0;
        step(2);
        reset_n = 1'b1;
        step(3);
        push("post_reset_coin", 3, 64'd0);
        push("post_reset_game", 5, 64'd0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            got = observe(e.sel);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", e.name, got, e.val);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_keyboard();
        test_joystick();
        test_socd();
        test_coin();
        test_game_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "timeout");
    end

endmodule
